sfifo: RTL

Single-clock synchronous FIFO; the same-clock counterpart and successor of the dual-clock FIFO wrapper. It adds selectable show-ahead or registered-read mode, an occupancy count, almost-full/almost-empty thresholds, and overflow/underflow pulses. Used for intra-domain buffering of AXI-side data and command streams where both ends share one clock.

---
 rtl/sfifo_pkg.sv | 13 +
 rtl/sfifo_if.sv | 31 +++
 rtl/sfifo_mem.sv | 24 ++
 rtl/sfifo.sv | 104 ++++++++++
 4 files changed

// File: rtl/sfifo_pkg.sv
// Shared sizing helpers for the single-clock FIFO.
package sfifo_pkg;

   function automatic int unsigned depth_of(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

   // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than a pointer.
   function automatic int unsigned cnt_w(input int unsigned aw);
      return aw + 32'd1;
   endfunction

endpackage

// File: rtl/sfifo_if.sv
// Producer/consumer bus of the single-clock FIFO: requests, data and status.
interface sfifo_if
   import sfifo_pkg::*;
#(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 128
) ();
   localparam int unsigned CW = cnt_w(AW);

   logic          we;
   logic          re;
   logic [DW-1:0] d;
   logic [DW-1:0] q;
   logic          wfull;
   logic          rempty;
   logic          afull;
   logic          aempty;
   logic [CW-1:0] count;
   logic          overflow;
   logic          underflow;

   modport master (
      output we, re, d,
      input  q, wfull, rempty, afull, aempty, count, overflow, underflow
   );

   modport slave (
      input  we, re, d,
      output q, wfull, rempty, afull, aempty, count, overflow, underflow
   );
endinterface

// File: rtl/sfifo_mem.sv
// DEPTH x DW storage: one synchronous write port, one asynchronous read port, no reset.
module sfifo_mem
   import sfifo_pkg::*;
#(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 128
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);
   localparam int unsigned DEPTH = depth_of(AW);

   logic [DW-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sfifo.sv
// Single-clock FIFO with show-ahead or registered read, occupancy count,
// almost-full/almost-empty thresholds and overflow/underflow pulses.
module sfifo
   import sfifo_pkg::*;
#(
   parameter int unsigned AW        = 4,
   parameter int unsigned DW        = 128,
   parameter int unsigned SHOWAHEAD = 1,
   parameter int unsigned AFULL_TH  = (32'd1 << AW) - 32'd1,
   parameter int unsigned AEMPTY_TH = 1
) (
   input  logic   clk,
   input  logic   reset,
   sfifo_if.slave bus
);
   localparam int unsigned DEPTH = depth_of(AW);
   localparam int unsigned CW    = cnt_w(AW);

   if (AW < 1) begin : g_bad_aw
      $error("sfifo: AW must be at least 1");
   end
   if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
      $error("sfifo: AFULL_TH must lie in 1..DEPTH");
   end
   if (AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
      $error("sfifo: AEMPTY_TH must lie in 0..DEPTH-1");
   end

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_wfull;
   logic          r_rempty;
   logic          r_afull;
   logic          r_aempty;
   logic          r_overflow;
   logic          r_underflow;

   logic          w_wr_acc;
   logic          w_rd_acc;
   logic          w_mem_we;
   logic [CW-1:0] w_count_next;
   logic [DW-1:0] w_rdata;

   // Acceptance looks only at this cycle's registered flags.
   always_comb begin
      w_wr_acc     = bus.we && !r_wfull;
      w_rd_acc     = bus.re && !r_rempty;
      w_mem_we     = w_wr_acc && !reset;
      w_count_next = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_wfull     <= 1'b0;
         r_rempty    <= 1'b1;
         r_afull     <= 1'b0;
         r_aempty    <= 1'b1;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
         if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
         r_count     <= w_count_next;
         r_wfull     <= (w_count_next == CW'(DEPTH));
         r_rempty    <= (w_count_next == '0);
         r_afull     <= (w_count_next >= CW'(AFULL_TH));
         r_aempty    <= (w_count_next <= CW'(AEMPTY_TH));
         r_overflow  <= bus.we && r_wfull;
         r_underflow <= bus.re && r_rempty;
      end
   end

   sfifo_mem #(.AW(AW), .DW(DW)) u_mem (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_waddr (r_wptr),
      .i_wdata (bus.d),
      .i_raddr (r_rptr),
      .o_rdata (w_rdata)
   );

   if (SHOWAHEAD != 0) begin : g_showahead
      assign bus.q = w_rdata;
   end else begin : g_regread
      logic [DW-1:0] r_q;
      always_ff @(posedge clk) begin
         if (reset)         r_q <= '0;
         else if (w_rd_acc) r_q <= w_rdata;
      end
      assign bus.q = r_q;
   end

   assign bus.count     = r_count;
   assign bus.wfull     = r_wfull;
   assign bus.rempty    = r_rempty;
   assign bus.afull     = r_afull;
   assign bus.aempty    = r_aempty;
   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;
endmodule
